// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch target buffer: update actions,
// counter encodings and PC index/tag slicing.
package bp_pkg;

  // Widest PC the slicing helpers accept; callers zero-extend into this.
  localparam int unsigned MAX_PC_W = 128;

  typedef logic [MAX_PC_W-1:0] pc_max_t;

  // What a resolved branch does to the table this cycle.
  typedef enum logic [1:0] {
    UPD_NONE  = 2'd0,
    UPD_TRAIN = 2'd1,
    UPD_ALLOC = 2'd2
  } upd_action_e;

  // Weakly taken: MSB set, remaining bits clear.
  function automatic int unsigned bp_weak_t(int unsigned ctr_w);
    return 32'd1 << (ctr_w - 1);
  endfunction

  // Weakly not-taken: MSB clear, remaining bits set (0 for a 1-bit counter).
  function automatic int unsigned bp_weak_nt(int unsigned ctr_w);
    return (32'd1 << (ctr_w - 1)) - 32'd1;
  endfunction

  // Table index: word-address bits just above the byte offset.
  function automatic pc_max_t bp_index(pc_max_t pc, int unsigned idx_w);
    return (pc >> 2) & ((pc_max_t'(1) << idx_w) - pc_max_t'(1));
  endfunction

  // Tag: everything above the index field.
  function automatic pc_max_t bp_tag(pc_max_t pc, int unsigned idx_w);
    return pc >> (idx_w + 2);
  endfunction

endpackage

// File: rtl/branch_predictor_sat_counter.sv
// Saturating up/down counter next-value logic for branch direction state.
module sat_counter #(
  parameter int CTR_W = 2
) (
  input  logic             en_i,
  input  logic             up_i,
  input  logic [CTR_W-1:0] value_i,
  output logic [CTR_W-1:0] next_o
);

  // Step toward taken or not-taken, holding at either end of the range.
  always_comb begin
    next_o = value_i;
    if (en_i) begin
      if (up_i) begin
        if (value_i != '1) next_o = value_i + CTR_W'(1);
      end else begin
        if (value_i != '0) next_o = value_i - CTR_W'(1);
      end
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Branch target buffer with per-entry direction counters. Combinational
// lookup from the fetch PC, one-cycle update from the resolving stage,
// whole-table invalidate and a saturating mispredict statistic.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int PC_W    = 64,
  parameter int ENTRIES = 16,
  parameter int CTR_W   = 2,
  parameter int STAT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [PC_W-1:0]   lookup_pc,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [PC_W-1:0]   pred_target,
  input  logic              upd_valid,
  input  logic [PC_W-1:0]   upd_pc,
  input  logic              upd_taken,
  input  logic [PC_W-1:0]   upd_target,
  input  logic              upd_mispredict,
  input  logic              inv_all,
  output logic [STAT_W-1:0] mispredict_count
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = PC_W - IDX_W - 2;

  localparam logic [CTR_W-1:0] WEAK_T  = CTR_W'(bp_weak_t(CTR_W));
  localparam logic [CTR_W-1:0] WEAK_NT = CTR_W'(bp_weak_nt(CTR_W));

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [PC_W-1:0]  target;
    logic [CTR_W-1:0] ctr;
  } entry_t;

  entry_t tbl_q [ENTRIES];
  entry_t tbl_d [ENTRIES];

  logic [STAT_W-1:0] cnt_q, cnt_d;

  logic [IDX_W-1:0] lk_idx, upd_idx;
  logic [TAG_W-1:0] lk_tag, upd_tag;
  logic             upd_hit;
  logic [CTR_W-1:0] ctr_next;
  upd_action_e      action;

  assign lk_idx  = IDX_W'(bp_index(pc_max_t'(lookup_pc), IDX_W));
  assign lk_tag  = TAG_W'(bp_tag(pc_max_t'(lookup_pc), IDX_W));
  assign upd_idx = IDX_W'(bp_index(pc_max_t'(upd_pc), IDX_W));
  assign upd_tag = TAG_W'(bp_tag(pc_max_t'(upd_pc), IDX_W));

  // Lookup reads the registered table, so a same-cycle update is not seen.
  always_comb begin
    pred_hit    = tbl_q[lk_idx].valid && (tbl_q[lk_idx].tag == lk_tag);
    pred_taken  = pred_hit && tbl_q[lk_idx].ctr[CTR_W-1];
    pred_target = pred_taken ? tbl_q[lk_idx].target : lookup_pc + PC_W'(4);
  end

  assign upd_hit = tbl_q[upd_idx].valid && (tbl_q[upd_idx].tag == upd_tag);

  // Classify the resolved branch: train a hit, allocate a taken miss.
  always_comb begin
    action = UPD_NONE;
    if (upd_valid) begin
      if (upd_hit)        action = UPD_TRAIN;
      else if (upd_taken) action = UPD_ALLOC;
    end
  end

  sat_counter #(.CTR_W(CTR_W)) u_ctr (
    .en_i    (action == UPD_TRAIN),
    .up_i    (upd_taken),
    .value_i (tbl_q[upd_idx].ctr),
    .next_o  (ctr_next)
  );

  // Next table contents; invalidate wins over the update in the same cycle.
  always_comb begin
    tbl_d = tbl_q;
    if (inv_all) begin
      for (int i = 0; i < ENTRIES; i++) tbl_d[i].valid = 1'b0;
    end else begin
      case (action)
        UPD_TRAIN: begin
          tbl_d[upd_idx].ctr = ctr_next;
          if (upd_taken) tbl_d[upd_idx].target = upd_target;
        end
        UPD_ALLOC: begin
          tbl_d[upd_idx].valid  = 1'b1;
          tbl_d[upd_idx].tag    = upd_tag;
          tbl_d[upd_idx].target = upd_target;
          tbl_d[upd_idx].ctr    = WEAK_T;
        end
        default: ;
      endcase
    end
  end

  // Mispredicts are counted even when the update itself is dropped.
  always_comb begin
    cnt_d = cnt_q;
    if (upd_valid && upd_mispredict && (cnt_q != '1)) cnt_d = cnt_q + STAT_W'(1);
  end

  // Table and statistic registers; reset clears every entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        tbl_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: WEAK_NT};
      end
      cnt_q <= '0;
    end else begin
      tbl_q <= tbl_d;
      cnt_q <= cnt_d;
    end
  end

  assign mispredict_count = cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

  localparam int PC_W   = 64;
  localparam int STAT_W = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [PC_W-1:0]   lookup_pc;
  logic              pred_hit, pred_taken;
  logic [PC_W-1:0]   pred_target;
  logic              upd_valid, upd_taken, upd_mispredict, inv_all;
  logic [PC_W-1:0]   upd_pc, upd_target;
  logic [STAT_W-1:0] mispredict_count;

  branch_predictor #(.PC_W(PC_W), .ENTRIES(16), .CTR_W(2), .STAT_W(STAT_W)) dut (
    .clk              (clk),
    .reset            (reset),
    .lookup_pc        (lookup_pc),
    .pred_hit         (pred_hit),
    .pred_taken       (pred_taken),
    .pred_target      (pred_target),
    .upd_valid        (upd_valid),
    .upd_pc           (upd_pc),
    .upd_taken        (upd_taken),
    .upd_target       (upd_target),
    .upd_mispredict   (upd_mispredict),
    .inv_all          (inv_all),
    .mispredict_count (mispredict_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string             name;
    logic              hit;
    logic              taken;
    logic [PC_W-1:0]   tgt;
    logic [STAT_W-1:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Monitor: outputs are sampled mid-cycle, one expectation per cycle.
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      vectors++;
      if (pred_hit !== e.hit || pred_taken !== e.taken ||
          pred_target !== e.tgt || mispredict_count !== e.cnt) begin
        miscompares++;
        $display("FAIL %s: got hit=%0b taken=%0b target=%h count=%0d, want hit=%0b taken=%0b target=%h count=%0d",
                 e.name, pred_hit, pred_taken, pred_target, mispredict_count,
                 e.hit, e.taken, e.tgt, e.cnt);
      end
    end
  end

  task automatic drive(input logic [PC_W-1:0] lpc, input logic uv, input logic [PC_W-1:0] upc,
                       input logic ut, input logic [PC_W-1:0] utgt, input logic umis,
                       input logic inv, input logic rst);
    lookup_pc = lpc; upd_valid = uv; upd_pc = upc; upd_taken = ut;
    upd_target = utgt; upd_mispredict = umis; inv_all = inv; reset = rst;
  endtask

  task automatic expect_now(input string name, input logic hit, input logic taken,
                            input logic [PC_W-1:0] tgt, input logic [STAT_W-1:0] cnt);
    exp_t e;
    e.name = name; e.hit = hit; e.taken = taken; e.tgt = tgt; e.cnt = cnt;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Lookup only, no update, with an expectation for this cycle.
  task automatic look(input string name, input logic [PC_W-1:0] lpc, input logic hit,
                      input logic taken, input logic [PC_W-1:0] tgt, input logic [STAT_W-1:0] cnt);
    drive(lpc, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    expect_now(name, hit, taken, tgt, cnt);
    tick();
  endtask

  // Update with no expectation.
  task automatic upd(input logic [PC_W-1:0] upc, input logic ut,
                     input logic [PC_W-1:0] utgt, input logic umis);
    drive(64'h0, 1'b1, upc, ut, utgt, umis, 1'b0, 1'b0);
    tick();
  endtask

  initial begin
    int unsigned c;
    drive('0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    tick(); tick();

    look("reset_lookup", 64'h100, 0, 0, 64'h104, 0);

    // Allocate 0x100 while looking it up: lookup sees the empty entry.
    drive(64'h100, 1'b1, 64'h100, 1'b1, 64'h40, 1'b1, 1'b0, 1'b0);
    expect_now("alloc_rbw", 0, 0, 64'h104, 0);
    tick();
    look("after_alloc", 64'h100, 1, 1, 64'h40, 1);

    // Train down: 10 -> 01 -> 00 -> 00, lookup during first update sees 10.
    drive(64'h100, 1'b1, 64'h100, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
    expect_now("nt1_rbw", 1, 1, 64'h40, 1);
    tick();
    look("ctr_01", 64'h100, 1, 0, 64'h104, 1);
    upd(64'h100, 1'b0, 64'h0, 1'b0);
    upd(64'h100, 1'b0, 64'h0, 1'b0);
    look("ctr_00_hold", 64'h100, 1, 0, 64'h104, 1);

    // Train up: 00 -> 01 (still not-taken) -> 10 (taken, new target).
    upd(64'h100, 1'b1, 64'h80, 1'b0);
    look("ctr_01_up", 64'h100, 1, 0, 64'h104, 1);
    upd(64'h100, 1'b1, 64'h80, 1'b0);
    look("ctr_10_up", 64'h100, 1, 1, 64'h80, 1);

    // Saturate at 11, then one not-taken still predicts taken.
    upd(64'h100, 1'b1, 64'h80, 1'b0);
    upd(64'h100, 1'b1, 64'h80, 1'b0);
    upd(64'h100, 1'b0, 64'h0, 1'b0);
    look("ctr_11_sat", 64'h100, 1, 1, 64'h80, 1);
    upd(64'h100, 1'b0, 64'h0, 1'b0);
    look("ctr_01_down", 64'h100, 1, 0, 64'h104, 1);

    // Aliasing on index 0: 0x140 replaces 0x100.
    upd(64'h140, 1'b1, 64'h200, 1'b1);
    look("alias_old_miss", 64'h100, 0, 0, 64'h104, 2);
    look("alias_new_hit", 64'h140, 1, 1, 64'h200, 2);

    // Not-taken miss leaves the table alone.
    upd(64'h180, 1'b0, 64'h0, 1'b0);
    look("nt_miss_keep", 64'h140, 1, 1, 64'h200, 2);
    look("nt_miss_noalloc", 64'h180, 0, 0, 64'h184, 2);

    // Second index; low two PC bits are ignored.
    upd(64'h204, 1'b1, 64'h300, 1'b0);
    look("idx1_hit", 64'h206, 1, 1, 64'h300, 2);

    // Invalidate with a same-cycle update (dropped but counted) and lookup.
    drive(64'h140, 1'b1, 64'h100, 1'b1, 64'h44, 1'b1, 1'b1, 1'b0);
    expect_now("inv_rbw", 1, 1, 64'h200, 2);
    tick();
    look("inv_miss_100", 64'h100, 0, 0, 64'h104, 3);
    look("inv_miss_140", 64'h140, 0, 0, 64'h144, 3);
    look("inv_miss_204", 64'h204, 0, 0, 64'h208, 3);

    look("pc4_wrap", 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 64'h0, 3);

    // Mispredict flag without upd_valid is not counted.
    drive(64'h100, 1'b0, 64'h100, 1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
    tick();
    look("mis_needs_valid", 64'h100, 0, 0, 64'h104, 3);

    // 20 counted mispredicts from 3: climbs to 15 and holds.
    c = 3;
    for (int k = 0; k < 20; k++) begin
      drive(64'h3000, 1'b1, 64'h180, 1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
      expect_now($sformatf("sat_step%0d", k), 0, 0, 64'h3004, STAT_W'(c));
      tick();
      if (c < 15) c++;
    end
    look("sat_hold", 64'h100, 0, 0, 64'h104, 15);

    // Reset mid-run drops a same-cycle update and empties everything.
    upd(64'h100, 1'b1, 64'h40, 1'b1);
    look("pre_reset_hit", 64'h100, 1, 1, 64'h40, 15);
    drive(64'h100, 1'b1, 64'h300, 1'b1, 64'h500, 1'b1, 1'b0, 1'b1);
    tick();
    look("post_reset_100", 64'h100, 0, 0, 64'h104, 0);
    look("post_reset_300", 64'h300, 0, 0, 64'h304, 0);

    drive('0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 10 && sb.size() != 0; k++) tick();
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
